// File: rtl/instr_l1_refill_ctrl.sv
// Miss/refill sequencer in front of the InstrL1 instruction cache.
// Define INSTR_L1_REFILL_BYPASS_EN to return the requested word straight from the fill burst.
module instr_l1_refill_ctrl #(
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned FLUSH_CYC  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ready,
  output logic              cpu_valid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              flush_req,
  output logic              l1_we,
  output logic [ADDR_W-1:0] l1_addr,
  output logic [DATA_W-1:0] l1_data,
  output logic              l1_flush,
  input  logic [DATA_W-1:0] l1_dout,
  input  logic              l1_hit,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned OFF_W = $clog2(LINE_WORDS);
  localparam int unsigned FC_W  = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  localparam logic [2:0] S_FLUSH    = 3'd0;
  localparam logic [2:0] S_IDLE     = 3'd1;
  localparam logic [2:0] S_LOOKUP   = 3'd2;
  localparam logic [2:0] S_MISS_REQ = 3'd3;
  localparam logic [2:0] S_FILL     = 3'd4;
  localparam logic [2:0] S_REPLAY   = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [OFF_W-1:0]  cnt_q, cnt_d;
  logic [FC_W-1:0]   fcnt_q, fcnt_d;
  logic              flush_pend_q, flush_pend_d;

  logic [ADDR_W-OFF_W-1:0] line;
  assign line = addr_q[ADDR_W-1:OFF_W];

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    fcnt_d       = fcnt_q;
    // A flush seen while busy is deferred until the controller is idle again.
    flush_pend_d = flush_pend_q | (flush_req & (state_q != S_IDLE));

    cpu_ready = 1'b0;
    cpu_valid = 1'b0;
    cpu_rdata = '0;
    l1_we     = 1'b0;
    l1_addr   = '0;
    l1_data   = '0;
    l1_flush  = 1'b0;
    mem_req   = 1'b0;
    mem_addr  = '0;

    case (state_q)
      S_FLUSH: begin
        l1_flush = 1'b1;
        if (fcnt_q == FC_W'(FLUSH_CYC - 1)) begin
          state_d = S_IDLE;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q + FC_W'(1);
        end
      end
      S_IDLE: begin
        cpu_ready = 1'b1;
        l1_addr   = cpu_addr;
        if (flush_req || flush_pend_q) begin
          state_d      = S_FLUSH;
          flush_pend_d = 1'b0;
        end else if (cpu_req) begin
          state_d = S_LOOKUP;
          addr_d  = cpu_addr;
        end
      end
      S_LOOKUP: begin
        l1_addr = addr_q;
        if (l1_hit) begin
          cpu_valid = 1'b1;
          cpu_rdata = l1_dout;
          state_d   = S_IDLE;
        end else begin
          state_d = S_MISS_REQ;
        end
      end
      S_MISS_REQ: begin
        mem_req  = 1'b1;
        mem_addr = {line, {OFF_W{1'b0}}};
        if (mem_ack) begin
          state_d = S_FILL;
          cnt_d   = '0;
        end
      end
      S_FILL: begin
        l1_addr = {line, cnt_q};
        if (mem_rvalid) begin
          l1_we   = 1'b1;
          l1_data = mem_rdata;
          cnt_d   = cnt_q + OFF_W'(1);
`ifdef INSTR_L1_REFILL_BYPASS_EN
          if (cnt_q == addr_q[OFF_W-1:0]) begin
            cpu_valid = 1'b1;
            cpu_rdata = mem_rdata;
          end
`endif
          if (cnt_q == {OFF_W{1'b1}}) begin
`ifdef INSTR_L1_REFILL_BYPASS_EN
            state_d = S_IDLE;
`else
            state_d = S_REPLAY;
`endif
          end
        end
      end
      S_REPLAY: begin
        state_d = S_LOOKUP;
      end
      default: begin
        state_d = S_FLUSH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_FLUSH;
      addr_q       <= '0;
      cnt_q        <= '0;
      fcnt_q       <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      fcnt_q       <= fcnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

endmodule

// File: tb/tb_instr_l1_refill_ctrl.sv
// Scoreboard bench for instr_l1_refill_ctrl with a word-valid InstrL1 model and a burst memory responder.
module tb_instr_l1_refill_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_req;
  logic [13:0] cpu_addr;
  logic        cpu_ready;
  logic        cpu_valid;
  logic [31:0] cpu_rdata;
  logic        flush_req;
  logic        l1_we;
  logic [13:0] l1_addr;
  logic [31:0] l1_data;
  logic        l1_flush;
  logic [31:0] l1_dout;
  logic        l1_hit;
  logic        mem_req;
  logic [13:0] mem_addr;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  instr_l1_refill_ctrl #(
    .ADDR_W(14), .DATA_W(32), .LINE_WORDS(8), .FLUSH_CYC(2)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ready(cpu_ready),
    .cpu_valid(cpu_valid), .cpu_rdata(cpu_rdata), .flush_req(flush_req),
    .l1_we(l1_we), .l1_addr(l1_addr), .l1_data(l1_data), .l1_flush(l1_flush),
    .l1_dout(l1_dout), .l1_hit(l1_hit),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  // InstrL1 model: per-word valid, combinational read, synchronous write/invalidate.
  bit          vld  [0:16383];
  logic [31:0] cdat [0:16383];
  assign l1_hit  = vld[l1_addr];
  assign l1_dout = cdat[l1_addr];
  always @(posedge clk) begin
    if (l1_flush) begin
      for (int i = 0; i < 16384; i++) vld[i] <= 1'b0;
    end else if (l1_we) begin
      vld[l1_addr]  <= 1'b1;
      cdat[l1_addr] <= l1_data;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Line 0x120 returns 32'hA000_0000 + k; other lines get distinct patterns.
  function automatic logic [31:0] memword(input logic [13:0] a);
    logic [13:0] b;
    b = {a[13:3], 3'b000} ^ 14'h0120;
    return 32'hA000_0000 + ({18'd0, b} << 8) + {29'd0, a[2:0]};
  endfunction

  logic [31:0] exp_rd_q[$];
  logic [13:0] exp_mem_q[$];

  int          wr_cnt_req = 0;
  int          wr_at_valid = 0;
  int          flush_cyc = 0;
  int          flush_at_mreq = 0;
  int          n_mem = 0;
  int          beat_idx = 0;
  bit          valid_seen = 0;
  logic [13:0] cur_line = '0;

`ifdef INSTR_L1_REFILL_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // Output monitor: samples on the falling edge.
  initial begin
    logic [31:0] e;
    logic [2:0]  bi;
    forever begin
      @(negedge clk);
      if (l1_flush) flush_cyc++;
      if (cpu_valid) begin
        valid_seen  = 1'b1;
        wr_at_valid = wr_cnt_req;
        if (exp_rd_q.size() == 0) begin
          chk("extra_valid", 32'd1, 32'd0);
        end else begin
          e = exp_rd_q.pop_front();
          chk("rdata", cpu_rdata, e);
        end
      end
      if (l1_we) begin
        bi = 3'(beat_idx);
        chk("wr_addr", {18'd0, l1_addr}, {18'd0, cur_line[13:3], bi});
        chk("wr_data", l1_data, memword(l1_addr));
        beat_idx++;
        wr_cnt_req++;
      end
    end
  end

  // Memory responder: ack, gap, then 8 beats each followed by a 1-cycle gap.
  initial begin
    logic [13:0] e;
    mem_ack    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(posedge clk); #1;
      if (mem_req === 1'b1) begin
        if (exp_mem_q.size() == 0) begin
          chk("unexp_memreq", 32'd1, 32'd0);
        end else begin
          e = exp_mem_q.pop_front();
          chk("mem_addr", {18'd0, mem_addr}, {18'd0, e});
        end
        flush_at_mreq = flush_cyc;
        cur_line      = mem_addr;
        beat_idx      = 0;
        n_mem++;
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        for (int k = 0; k < 8; k++) begin
          @(posedge clk); #1;
          mem_rvalid = 1'b1;
          mem_rdata  = memword({cur_line[13:3], 3'(k)});
          @(posedge clk); #1;
          mem_rvalid = 1'b0;
        end
      end
    end
  end

  task automatic fetch(input logic [13:0] a, input logic [31:0] exp, input bit exp_miss,
                       input bit with_flush, input bit chk_lat);
    int n;
    int m0;
    @(negedge clk);
    n = 0;
    while (cpu_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    exp_rd_q.push_back(exp);
    if (exp_miss) exp_mem_q.push_back({a[13:3], 3'b000});
    m0         = n_mem;
    wr_cnt_req = 0;
    valid_seen = 1'b0;
    flush_cyc  = 0;
    cpu_req    = 1'b1;
    cpu_addr   = a;
    if (with_flush) begin
      flush_req = 1'b1;
      @(posedge clk); #1;
      flush_req = 1'b0;
    end
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!valid_seen && n < 300);
    cpu_req = 1'b0;
    if (!valid_seen) begin
      chk("valid_timeout", 32'd0, 32'd1);
      exp_rd_q.delete();
      exp_mem_q.delete();
    end else begin
      chk("missed", 32'(n_mem - m0), {31'd0, exp_miss});
      if (chk_lat) chk("hit_lat", 32'(n), 32'd2);
      if (exp_miss) chk("wr_before_valid", 32'(wr_at_valid), BYP ? {29'd0, a[2:0]} : 32'd8);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    reset_n   = 1'b1;
    cpu_req   = 1'b0;
    cpu_addr  = '0;
    flush_req = 1'b0;
    #1 reset_n = 1'b0;

    // Test 1: reset and post-release flush window.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_flush", {31'd0, l1_flush}, 32'd1);
    chk("rst_ready", {31'd0, cpu_ready}, 32'd0);
    chk("rst_memreq", {31'd0, mem_req}, 32'd0);
    chk("rst_valid", {31'd0, cpu_valid}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("rel_flush", {31'd0, l1_flush}, (i <= 2) ? 32'd1 : 32'd0);
      chk("rel_ready", {31'd0, cpu_ready}, (i == 3) ? 32'd1 : 32'd0);
      chk("rel_memreq", {31'd0, mem_req}, 32'd0);
    end

    // Test 2: cold miss; Test 3: back-to-back hit.
    fetch(14'h0123, 32'hA000_0003, 1'b1, 1'b0, 1'b0);
    fetch(14'h0125, 32'hA000_0005, 1'b0, 1'b0, 1'b1);

    // Test 4: flush_req mid-fill is deferred until the fill and request complete.
    wr_cnt_req = 0;
    fork
      fetch(14'h0203, memword(14'h0203), 1'b1, 1'b0, 1'b0);
      begin
        w = 0;
        while (wr_cnt_req < 3 && w < 200) begin
          @(posedge clk);
          w++;
        end
        #1 flush_req = 1'b1;
        @(posedge clk); #1;
        flush_req = 1'b0;
      end
    join
    repeat (30) @(posedge clk);
    chk("fill_done_beats", 32'(wr_cnt_req), 32'd8);
    chk("deferred_flush_cyc", 32'(flush_cyc), 32'd2);
    fetch(14'h0125, 32'hA000_0005, 1'b1, 1'b0, 1'b0);

    // Every offset of the refilled line hits, including both ends.
    for (int k = 0; k < 8; k++)
      fetch({11'h024, 3'(k)}, 32'hA000_0000 + 32'(k), 1'b0, 1'b0, 1'b1);

    // Test 5: reset mid-fill after beat 4.
    @(posedge clk); #1;
    wr_cnt_req = 0;
    exp_mem_q.push_back(14'h0300);
    cpu_req  = 1'b1;
    cpu_addr = 14'h0305;
    w = 0;
    while (wr_cnt_req < 5 && w < 200) begin
      @(posedge clk);
      w++;
    end
    if (w >= 200) chk("beat4_timeout", 32'd0, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_flush", {31'd0, l1_flush}, 32'd1);
    chk("arst_ready", {31'd0, cpu_ready}, 32'd0);
    chk("arst_memreq", {31'd0, mem_req}, 32'd0);
    chk("arst_we", {31'd0, l1_we}, 32'd0);
    chk("arst_valid", {31'd0, cpu_valid}, 32'd0);
    chk("arst_l1addr", {18'd0, l1_addr}, 32'd0);
    chk("arst_l1data", l1_data, 32'd0);
    repeat (3) @(posedge clk);
    #1 cpu_req = 1'b0;
    reset_n = 1'b1;
    fetch(14'h0305, memword(14'h0305), 1'b1, 1'b0, 1'b0);

    // Test 6: simultaneous cpu_req and flush_req.
    fetch(14'h0405, memword(14'h0405), 1'b1, 1'b1, 1'b0);
    chk("flush_before_memreq", 32'(flush_at_mreq), 32'd2);

    // Bypass boundary offsets: last and first word of a line.
    fetch(14'h0507, memword(14'h0507), 1'b1, 1'b0, 1'b0);
    fetch(14'h0600, memword(14'h0600), 1'b1, 1'b0, 1'b0);
    fetch(14'h0507, memword(14'h0507), 1'b0, 1'b0, 1'b1);

    repeat (30) @(posedge clk);
    chk("queue_drained", 32'(exp_rd_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
